// File: rtl/eth_10g_mac_tx_st_mux_rr.sv
// -----------------------------------------------------------------------------
// eth_10g_mac_tx_st_mux_rr
//
// Purpose:
//   Avalon-ST packet multiplexer for the 10G MAC TX path. It merges several
//   packet streams (user frames, pause/PFC frames, diagnostic generators) onto
//   one MAC TX stream. Arbitration happens only at packet boundaries, so
//   packets are never interleaved. The arbiter is either round-robin or fixed
//   priority (lowest index wins). A single output register stage carries the
//   payload and the index of the source input on out_channel.
//
// Ports:
//   clk                clock, all logic on the rising edge
//   reset              synchronous, active-high reset
//   in_valid/in_ready  per-input handshake (NUM_INPUTS bits each)
//   in_data            input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_error           input i at [i*ERROR_WIDTH +: ERROR_WIDTH]
//   in_startofpacket   per-input SOP
//   in_endofpacket     per-input EOP
//   in_empty           input i at [i*EMPTY_WIDTH +: EMPTY_WIDTH]
//   out_valid/out_ready output handshake
//   out_data, out_error, out_startofpacket, out_endofpacket, out_empty
//                      registered payload of the selected input
//   out_channel        index of the source input of the current output beat
//   grant_locked       high while a packet is in progress (status only)
// -----------------------------------------------------------------------------
module eth_10g_mac_tx_st_mux_rr #(
  parameter int NUM_INPUTS    = 2,
  parameter int CHANNEL_WIDTH = 1,
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = 3,
  parameter int ERROR_WIDTH   = 2,
  parameter int ARB_MODE      = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  output logic [NUM_INPUTS-1:0]             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_INPUTS*ERROR_WIDTH-1:0] in_error,
  input  logic [NUM_INPUTS-1:0]             in_startofpacket,
  input  logic [NUM_INPUTS-1:0]             in_endofpacket,
  input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ERROR_WIDTH-1:0]            out_error,
  output logic                              out_startofpacket,
  output logic                              out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]            out_empty,
  output logic [CHANNEL_WIDTH-1:0]          out_channel,
  output logic                              grant_locked
);

  localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEL_W-1:0] select_r;
  logic [SEL_W-1:0] select_nxt_s;
  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] rr_ptr_nxt_s;

  logic             sel_valid_s;
  logic             sel_ready_s;
  logic             sel_eop_s;
  logic             accept_s;
  logic [SEL_W-1:0] pick_idle_s;
  logic [SEL_W-1:0] pick_after_eop_s;

  // Arbitration decision. Round-robin searches ptr+1, ptr+2, ... with wrap;
  // fixed priority takes the lowest valid index. With nothing valid the
  // current selection is kept. Loops run from the least preferred candidate
  // to the most preferred one so the last hit is the winner.
  function automatic logic [SEL_W-1:0] arb_pick(
    input logic [NUM_INPUTS-1:0] valid,
    input logic [SEL_W-1:0]      ptr,
    input logic [SEL_W-1:0]      hold
  );
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = hold;
    if (ARB_MODE == 1) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (valid[i]) pick = SEL_W'(i);
        else          pick = pick;
      end
    end else begin
      for (int k = NUM_INPUTS; k >= 1; k--) begin
        idx = SEL_W'((int'(ptr) + k) % NUM_INPUTS);
        if (valid[idx]) pick = idx;
        else            pick = pick;
      end
    end
    return pick;
  endfunction

  // Handshake on the currently selected input.
  always_comb begin
    sel_valid_s      = in_valid[select_r];
    sel_eop_s        = in_endofpacket[select_r];
    sel_ready_s      = out_ready | ~out_valid;
    accept_s         = sel_valid_s & sel_ready_s;
    pick_idle_s      = arb_pick(in_valid, rr_ptr_r, select_r);
    // After an EOP the pointer moves to the finishing input, so the next
    // decision is made against that updated pointer (no bubble between packets).
    pick_after_eop_s = arb_pick(in_valid, select_r, select_r);
  end

  // Back-pressure: only the selected input may see ready; the rest are held.
  always_comb begin
    in_ready           = {NUM_INPUTS{1'b0}};
    in_ready[select_r] = sel_ready_s;
  end

  // Next-state logic for the packet lock, selection and round-robin pointer.
  always_comb begin
    state_nxt_s  = state_r;
    select_nxt_s = select_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !sel_eop_s) begin
          // First beat of a multi-beat packet: freeze the selection.
          state_nxt_s  = ST_LOCKED;
          rr_ptr_nxt_s = select_r;
        end else if (accept_s) begin
          // Single-beat packet: stay idle but rotate the pointer.
          rr_ptr_nxt_s = select_r;
          select_nxt_s = pick_after_eop_s;
        end else begin
          select_nxt_s = pick_idle_s;
        end
      end
      ST_LOCKED: begin
        if (accept_s && sel_eop_s) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = select_r;
          select_nxt_s = pick_after_eop_s;
        end else begin
          state_nxt_s  = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        select_nxt_s = {SEL_W{1'b0}};
        rr_ptr_nxt_s = SEL_W'(NUM_INPUTS - 1);
      end
    endcase
  end

  // Arbiter state registers; the pointer resets to the last input so input 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      select_r <= {SEL_W{1'b0}};
      rr_ptr_r <= SEL_W'(NUM_INPUTS - 1);
    end else begin
      state_r  <= state_nxt_s;
      select_r <= select_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Output register stage: load on acceptance, drain on out_ready, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= {DATA_WIDTH{1'b0}};
      out_error         <= {ERROR_WIDTH{1'b0}};
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= {EMPTY_WIDTH{1'b0}};
      out_channel       <= {CHANNEL_WIDTH{1'b0}};
    end else if (accept_s) begin
      out_valid         <= 1'b1;
      out_data          <= in_data[select_r*DATA_WIDTH +: DATA_WIDTH];
      out_error         <= in_error[select_r*ERROR_WIDTH +: ERROR_WIDTH];
      out_startofpacket <= in_startofpacket[select_r];
      out_endofpacket   <= sel_eop_s;
      out_empty         <= in_empty[select_r*EMPTY_WIDTH +: EMPTY_WIDTH];
      out_channel       <= CHANNEL_WIDTH'(select_r);
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end else begin
      out_valid         <= out_valid;
    end
  end

  assign grant_locked = (state_r == ST_LOCKED);

endmodule

// File: doc/eth_10g_mac_tx_st_mux_rr.md
Name: eth_10g_mac_tx_st_mux_rr

Overview:
N-input Avalon-ST packet multiplexer for the 10G MAC TX path. It merges user frames, pause/PFC frames and diagnostic generators onto one MAC TX stream. Arbitration happens only at packet boundaries, using round-robin or fixed priority, so packets are never interleaved. A registered output stage carries the source index on out_channel.

Parameters:
NUM_INPUTS, 2, number of input streams (2..8)
CHANNEL_WIDTH, 1, out_channel width; must be >= clog2(NUM_INPUTS)
DATA_WIDTH, 64, data bits per beat
EMPTY_WIDTH, 3, empty field width (log2 of DATA_WIDTH/8)
ERROR_WIDTH, 2, error field width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  NUM_INPUTS  per-input valid
in_ready  out  NUM_INPUTS  per-input ready
in_data  in  NUM_INPUTS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_error  in  NUM_INPUTS*ERROR_WIDTH  packed like in_data
in_startofpacket  in  NUM_INPUTS  per-input SOP
in_endofpacket  in  NUM_INPUTS  per-input EOP
in_empty  in  NUM_INPUTS*EMPTY_WIDTH  packed like in_data
out_valid  out  1  output valid
out_ready  in  1  output ready
out_data  out  DATA_WIDTH  selected data
out_error  out  ERROR_WIDTH  selected error
out_startofpacket  out  1  selected SOP
out_endofpacket  out  1  selected EOP
out_empty  out  EMPTY_WIDTH  selected empty
out_channel  out  CHANNEL_WIDTH  index of the source input for the current output beat
grant_locked  out  1  high while a packet is in progress (status only)

Behaviour:
- Reset (synchronous, reset=1 at rising clk):
  - out_valid=0; all out_* payload fields=0; out_channel=0; grant_locked=0.
  - State=IDLE; select=0; rr_ptr=NUM_INPUTS-1, so input 0 wins first.
- A reset mid-packet abandons the packet. No EOP is synthesised.
- States:
  - IDLE: no packet in progress. select is set to the combinational decision each cycle.
  - LOCKED: select is frozen until an EOP beat is accepted.
- Decision, round-robin: first valid input searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_INPUTS wrap.
- Decision, fixed priority: lowest-index valid input.
- Decision, no input valid: select holds its current value.
- Acceptance is defined as sel_valid && sel_ready, where sel_valid=in_valid[select].
- IDLE -> LOCKED: a non-EOP beat is accepted. rr_ptr<=select.
- LOCKED -> IDLE: an EOP beat is accepted. rr_ptr<=select.
- Back-to-back packets: in the cycle an EOP is accepted, select<=decision for the next cycle, computed with the updated pointer. There is no idle bubble between packets.
- Single-beat packet (SOP and EOP in the same beat) accepted in IDLE: remain IDLE and update rr_ptr.
- SOP is not checked. The first valid beat after IDLE starts a packet. The upstream is required to be well-formed.
- Back-pressure:
  - in_ready[select]=sel_ready.
  - Every other in_ready=0. Non-selected inputs are held, never dropped.
- Output stage: one register.
  - sel_ready = out_ready || !out_valid.
  - On acceptance: out payload <= selected fields, out_channel<=select, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - Else: hold. Payload must be stable while out_valid && !out_ready.
- Latency: 1 cycle from input acceptance to out_valid. Throughput: one beat per cycle while out_ready=1.
- grant_locked = (state==LOCKED).
- Channel change: out_channel may change only on a beat that follows an accepted EOP.

Test Plan:
- NUM_INPUTS=4, RR, all inputs continuously valid with 3-beat packets, out_ready=1 -> out_channel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; no gaps in out_valid.
- ARB_MODE=1, inputs 1 and 3 valid with 2-beat packets -> only channel 1 packets appear while input 1 stays valid; in_ready[3]=0 throughout.
- Input 2 mid-packet, input 0 asserts valid -> input 0 held (in_ready[0]=0) until input 2 EOP is accepted; input 0 SOP appears the following cycle.
- out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_channel stable; in_ready[select]=0; on release, no beats are lost or duplicated.
- Single-beat packets on inputs 0 and 1 alternating -> channels 0,1,0,1; grant_locked stays 0.
- Reset asserted on beat 2 of a 4-beat packet -> next cycle out_valid=0, grant_locked=0; input 0 is granted first after reset.
